// File: rtl/decoder_pkg.sv
// Shared types for the one-hot decoder pipeline: FSM state, result layout, counter width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package decoder_pkg;

  localparam int ERR_CNT_W   = 16;
  // Widest legal output count (IN_W = 8); result words are laid out at this width.
  localparam int DEC_MAX_OUT = 256;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } decoder_state_e;

  // Decoded result in its widest form; narrower configurations use y[NUM_OUT-1:0].
  typedef struct packed {
    logic [DEC_MAX_OUT-1:0] y;
    logic                   err;
  } decoder_result_t;

endpackage

// File: rtl/decoder_onehot_core.sv
// Combinational binary-to-one-hot decode with polarity and out-of-range flag.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; output follows code_i directly.
//
// Ports:
//   code_i  binary code to decode
//   y_o     decoded word; selected bit active, all others inactive (ACTIVE_LOW inverts)
//   err_o   1 when code_i >= NUM_OUT (y_o is then all inactive)
module decoder_onehot_core #(
  parameter int IN_W       = 3,
  parameter int NUM_OUT    = 8,
  parameter int ACTIVE_LOW = 0
) (
  input  logic [IN_W-1:0]    code_i,
  output logic [NUM_OUT-1:0] y_o,
  output logic               err_o
);

  logic [NUM_OUT-1:0] hot;

  always_comb begin
    hot   = '0;
    err_o = 1'b1;
    // A code with no matching output leaves hot at zero and err set.
    for (int i = 0; i < NUM_OUT; i++) begin
      if (code_i == IN_W'(i)) begin
        hot[i] = 1'b1;
        err_o  = 1'b0;
      end
    end
    y_o = (ACTIVE_LOW != 0) ? ~hot : hot;
  end

endmodule

// File: rtl/decoder_onehot_pipe.sv
// Registered binary-to-one-hot decoder with a 2-entry skid buffer and valid/ready on both sides.
// Latency: 1 cycle from input transfer to y_o/err_o; 1 result per cycle sustained.
// Backpressure: in_ready_o is registered; one extra code is absorbed in the skid slot after a stall.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   in_valid_i/in_ready_o, d_i   input handshake and binary code
//   out_valid_o/out_ready_i      output handshake
//   y_o, err_o                   decoded word (polarity per ACTIVE_LOW) and out-of-range flag
//   err_cnt_o                    saturating count of erroring output transfers
//                                (present only when DECODER_ERR_CNT_EN is defined)
module decoder_onehot_pipe
  import decoder_pkg::*;
#(
  parameter int IN_W       = 3,
  parameter int NUM_OUT    = 8,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [IN_W-1:0]      d_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [NUM_OUT-1:0]   y_o,
  output logic                 err_o
`ifdef DECODER_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0] err_cnt_o
`endif
);

  localparam logic [NUM_OUT-1:0] IDLE_Y = {NUM_OUT{ACTIVE_LOW != 0}};

  decoder_state_e     state_q, state_d;
  logic [NUM_OUT-1:0] main_y_q, main_y_d;
  logic               main_err_q, main_err_d;
  logic [NUM_OUT-1:0] skid_y_q, skid_y_d;
  logic               skid_err_q, skid_err_d;
  logic               in_rdy_q, in_rdy_d;
  logic               out_vld_q, out_vld_d;

  logic [NUM_OUT-1:0] dec_y;
  logic               dec_err;
  logic               in_xfer;
  logic               out_xfer;

  decoder_onehot_core #(
    .IN_W       (IN_W),
    .NUM_OUT    (NUM_OUT),
    .ACTIVE_LOW (ACTIVE_LOW)
  ) u_core (
    .code_i (d_i),
    .y_o    (dec_y),
    .err_o  (dec_err)
  );

  assign in_xfer  = in_valid_i && in_rdy_q;
  assign out_xfer = out_vld_q && out_ready_i;

  always_comb begin
    state_d    = state_q;
    main_y_d   = main_y_q;
    main_err_d = main_err_q;
    skid_y_d   = skid_y_q;
    skid_err_d = skid_err_q;
    case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          main_y_d   = dec_y;
          main_err_d = dec_err;
          state_d    = ONE;
        end
      end
      ONE: begin
        if (in_xfer && !out_xfer) begin
          // Consumer stalled: park the new result behind the one on the output.
          skid_y_d   = dec_y;
          skid_err_d = dec_err;
          state_d    = FULL;
        end else if (in_xfer && out_xfer) begin
          main_y_d   = dec_y;
          main_err_d = dec_err;
        end else if (out_xfer) begin
          state_d    = EMPTY;
        end
      end
      FULL: begin
        if (out_xfer) begin
          main_y_d   = skid_y_q;
          main_err_d = skid_err_q;
          state_d    = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Handshake outputs are registered from the next state so neither
    // depends combinationally on out_ready_i.
    in_rdy_d  = (state_d != FULL);
    out_vld_d = (state_d != EMPTY);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= EMPTY;
      main_y_q   <= IDLE_Y;
      main_err_q <= 1'b0;
      skid_y_q   <= IDLE_Y;
      skid_err_q <= 1'b0;
      in_rdy_q   <= 1'b1;
      out_vld_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      main_y_q   <= main_y_d;
      main_err_q <= main_err_d;
      skid_y_q   <= skid_y_d;
      skid_err_q <= skid_err_d;
      in_rdy_q   <= in_rdy_d;
      out_vld_q  <= out_vld_d;
    end
  end

  assign in_ready_o  = in_rdy_q;
  assign out_valid_o = out_vld_q;
  assign y_o         = main_y_q;
  assign err_o       = main_err_q;

`ifdef DECODER_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    // Saturate rather than wrap so a flood of bad codes stays visible.
    if (out_xfer && main_err_q && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_decoder_onehot_pipe.sv
// Testbench for decoder_onehot_pipe: default, active-low and narrow (NUM_OUT=6) instances.
// Latency: n/a.
// Backpressure: exercised through out_ready stalls and random ready toggling.
module tb_decoder_onehot_pipe;
  import decoder_pkg::*;

  localparam int CW = DEC_MAX_OUT + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // default instance
  logic       in_valid = 1'b0, out_ready = 1'b0;
  logic [2:0] d = '0;
  logic       in_ready, out_valid, err;
  logic [7:0] y;
  // active-low instance
  logic       lo_valid = 1'b0, lo_ordy = 1'b0;
  logic [2:0] lo_d = '0;
  logic       lo_ready, lo_ovld, lo_err;
  logic [7:0] lo_y;
  // narrow instance (NUM_OUT = 6)
  logic       nr_valid = 1'b0, nr_ordy = 1'b0;
  logic [2:0] nr_d = '0;
  logic       nr_ready, nr_ovld, nr_err;
  logic [5:0] nr_y;
`ifdef DECODER_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] cnt, lo_cnt, nr_cnt;
`endif

  decoder_onehot_pipe #(.IN_W(3), .NUM_OUT(8), .ACTIVE_LOW(0)) u_dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready), .d_i(d),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .y_o(y), .err_o(err)
`ifdef DECODER_ERR_CNT_EN
    , .err_cnt_o(cnt)
`endif
  );

  decoder_onehot_pipe #(.IN_W(3), .NUM_OUT(8), .ACTIVE_LOW(1)) u_low (
    .clk_i(clk), .rst_i(rst), .in_valid_i(lo_valid), .in_ready_o(lo_ready), .d_i(lo_d),
    .out_valid_o(lo_ovld), .out_ready_i(lo_ordy), .y_o(lo_y), .err_o(lo_err)
`ifdef DECODER_ERR_CNT_EN
    , .err_cnt_o(lo_cnt)
`endif
  );

  decoder_onehot_pipe #(.IN_W(3), .NUM_OUT(6), .ACTIVE_LOW(0)) u_nar (
    .clk_i(clk), .rst_i(rst), .in_valid_i(nr_valid), .in_ready_o(nr_ready), .d_i(nr_d),
    .out_valid_o(nr_ovld), .out_ready_i(nr_ordy), .y_o(nr_y), .err_o(nr_err)
`ifdef DECODER_ERR_CNT_EN
    , .err_cnt_o(nr_cnt)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;
  int n_in   = 0;
  int n_out  = 0;
  int cyc    = 0;
  decoder_result_t sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic decoder_result_t model(input int code, input int n, input bit al);
    decoder_result_t r;
    r = '0;
    for (int i = 0; i < n; i++) r.y[i] = al;
    if (code < n) r.y[code] = ~al;
    else          r.err = 1'b1;
    return r;
  endfunction

  function automatic decoder_result_t obs(input logic [DEC_MAX_OUT-1:0] yv, input logic e);
    decoder_result_t r;
    r.y   = yv;
    r.err = e;
    return r;
  endfunction

  // Scoreboard: push on input transfer, pop and compare on output transfer.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) check("sb_underflow", CW'(1), CW'(0));
        else                check("sb_data", obs({248'b0, y}, err), sb.pop_front());
        n_out++;
      end
      if (in_valid && in_ready) begin
        sb.push_back(model(int'(d), 8, 1'b0));
        n_in++;
      end
    end
  end

  // Offer one code; returns at posedge+1 after the edge that accepted it.
  task automatic send(input int code);
    int  guard;
    logic acc;
    guard    = 0;
    in_valid = 1'b1;
    d        = 3'(code);
    forever begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
      guard++;
      if (guard > 200) begin
        check("send_timeout", CW'(0), CW'(1));
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int g;
    g = 0;
    while (sb.size() != 0 && g < 100) begin
      @(posedge clk);
      #1;
      g++;
    end
    @(posedge clk);
    #1;
    check(tag, CW'(sb.size()), CW'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, n_chk=%0d", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, base, n0;
    bit done;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  CW'(in_ready),  CW'(1));
    check("rst_out_valid", CW'(out_valid), CW'(0));
    check("rst_y",         CW'(y),         CW'(0));
    check("rst_err",       CW'(err),       CW'(0));
    check("rst_low_y",     CW'(lo_y),      CW'(8'hFF));
    check("rst_nar_y",     CW'(nr_y),      CW'(0));
`ifdef DECODER_ERR_CNT_EN
    check("rst_cnt",       CW'(cnt),       CW'(0));
`endif
    rst = 1'b0;

    // Active-low decode of code 5
    lo_ordy  = 1'b1;
    lo_valid = 1'b1;
    lo_d     = 3'd5;
    @(posedge clk);
    #1;
    lo_valid = 1'b0;
    @(negedge clk);
    check("low_valid", CW'(lo_ovld), CW'(1));
    check("low_code5", obs({248'b0, lo_y}, lo_err), model(5, 8, 1'b1));

    // Out-of-range codes 6 and 7 on the 6-output instance
    @(posedge clk);
    #1;
    nr_ordy  = 1'b1;
    nr_valid = 1'b1;
    nr_d     = 3'd6;
    @(posedge clk);
    #1;
    nr_d = 3'd7;
    @(negedge clk);
    check("nar_code6", obs({250'b0, nr_y}, nr_err), model(6, 6, 1'b0));
    @(posedge clk);
    #1;
    nr_valid = 1'b0;
    @(negedge clk);
    check("nar_code7", obs({250'b0, nr_y}, nr_err), model(7, 6, 1'b0));
    @(posedge clk);
    @(negedge clk);
    check("nar_drained", CW'(nr_ovld), CW'(0));
`ifdef DECODER_ERR_CNT_EN
    check("nar_cnt2", CW'(nr_cnt), CW'(2));
`endif

    // Sweep 0..7 with the consumer always ready: one result per cycle
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    t0   = cyc;
    base = n_out;
    for (int i = 0; i < 8; i++) send(i);
    check("sweep_cycles", CW'(cyc - t0), CW'(8));
    @(posedge clk);
    #1;
    check("sweep_outputs", CW'(n_out - base), CW'(8));
    check("sweep_idle",    CW'(out_valid),    CW'(0));

    // Stall: 1 and 2 accepted, 3 held off, output stable
    out_ready = 1'b0;
    n0 = n_out;
    send(1);
    send(2);
    in_valid = 1'b1;
    d        = 3'd3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_in_ready",  CW'(in_ready),  CW'(0));
      check("stall_out_valid", CW'(out_valid), CW'(1));
      check("stall_y",         obs({248'b0, y}, err), model(1, 8, 1'b0));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(3);
    drain("stall_drain");
    check("stall_outputs", CW'(n_out - n0), CW'(3));

    // Reset while FULL
    out_ready = 1'b0;
    send(4);
    send(5);
    @(negedge clk);
    check("full_in_ready", CW'(in_ready), CW'(0));
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    check("midrst_out_valid", CW'(out_valid), CW'(0));
    check("midrst_in_ready",  CW'(in_ready),  CW'(1));
    check("midrst_y",         CW'(y),         CW'(0));
    out_ready = 1'b1;
    send(6);
    check("post_rst_y", obs({248'b0, y}, err), model(6, 8, 1'b0));
    drain("post_rst_drain");

    // Random codes against random consumer stalls
    n0   = n_in;
    base = n_out;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) send(int'($urandom_range(0, 7)));
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    drain("rand_drain");
    check("rand_in_count",  CW'(n_in - n0),    CW'(40));
    check("rand_out_count", CW'(n_out - base), CW'(40));

`ifdef DECODER_ERR_CNT_EN
    // Counter saturation on the narrow instance
    nr_ordy  = 1'b1;
    nr_valid = 1'b1;
    nr_d     = 3'd7;
    repeat (65540) @(posedge clk);
    #1;
    nr_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("cnt_saturate", CW'(nr_cnt), CW'(16'hFFFF));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
